delta_hid: RTL and testbench
============================

Name: delta_hid

Overview:
- Hidden-layer delta engine for backpropagation.
- Accepts N_OUT next-layer output deltas and their connecting weights as a serial beat stream.
- Computes delta_h = (sum_k delta_k * w_k) * a*(1-a) in signed fixed point, then presents the result through a hold-until-acknowledged output.
- One instance per hidden neuron; it is fed by the output-layer delta stage and feeds the weight-update logic.

Parameters:
- WIDTH, 32, data word width (signed two's complement).
- FRAC, 24, fractional bits (Q8.24 at defaults; 1.0 = 0x01000000).
- N_OUT, 2, number of delta/weight beats per operation (>=1).
- GUARD, 8, extra accumulator MSBs above WIDTH.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous, active-high.
- i_start, in, 1, begins an operation; honoured only in IDLE.
- i_a, in, WIDTH, hidden activation; latched on an accepted i_start.
- i_valid, in, 1, delta/weight beat present.
- i_delta, in, WIDTH, next-layer delta for the current beat.
- i_w, in, WIDTH, weight for the current beat.
- o_ready, out, 1, high only in ACC; a beat is accepted when i_valid && o_ready.
- o_valid, out, 1, result valid; held until i_ack.
- o_delta, out, WIDTH, hidden delta result.
- i_ack, in, 1, consumer acknowledge; effective only while o_valid is high.
- o_busy, out, 1, high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, acc=0, cnt=0, a_reg=0, sd=0. Outputs o_valid=0, o_delta=0, o_ready=0, o_busy=0. Reset wins over every other input and abandons any operation in progress, with no output produced.
- Fixed-point multiply fmul(x,y): full 2*WIDTH signed product, arithmetic shift right by FRAC, keep low WIDTH bits (truncate toward -inf).
- FSM states: IDLE, ACC, SD, MUL, DONE.
  - IDLE: on i_start, latch a_reg=i_a, acc=0, cnt=0, go to ACC.
  - ACC: o_ready=1. Each accepted beat: acc += sign-extend(fmul(i_delta,i_w)) to WIDTH+GUARD bits; cnt++. The beat that takes cnt to N_OUT moves to SD. Idle cycles (i_valid=0) are allowed indefinitely.
  - SD: sd = fmul(a_reg, ONE - a_reg), where ONE = 1<<FRAC; go to MUL.
  - MUL: o_delta = fmul(clip(acc), sd); o_valid=1; go to DONE.
  - DONE: hold o_delta and o_valid. When i_ack=1, clear o_valid (o_delta keeps its value) and go to IDLE.
- clip(acc) without the macro: low WIDTH bits (wrap).
- Latency: last beat accepted at edge k means o_valid is high after edge k+2. Minimum start-to-result time is N_OUT+3 edges.
- Ignored inputs:
  - i_start outside IDLE, including when it coincides with i_ack in DONE.
  - i_valid outside ACC.
  - i_ack outside DONE.
- a_reg is never re-latched mid-operation.

Optional Feature:
- DELTA_HID_SAT_EN defined: clip(acc) saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The final MUL product also saturates: the full shifted product is clamped to the WIDTH range instead of being truncated.
- Undefined: both steps wrap (low WIDTH bits).
- Latency is identical in both builds.

Decomposition:
- Shared package delta_pkg holds:
  - the FSM state enum (IDLE, ACC, SD, MUL, DONE);
  - the function/constant for ONE;
  - the signed saturate helper.
- One sub-module, fx_mult: combinational fmul with WIDTH/FRAC parameters and a saturate-enable parameter. It is instantiated for the beat product, the sigmoid derivative and the final product.

Test Plan (defaults, N_OUT=2):
- Basic: a=0x00800000 (0.5); beats (0x00800000, 0x01000000) and (0x00400000, 0x02000000). sum=1.0, sd=0x00400000, so o_delta=0x00400000. o_valid rises 2 edges after the second beat.
- Negative: a=0x00C00000 (0.75); beats (0xFF000000, 0x01000000) and (0, 0x12345678). o_delta=0xFFD00000 (-0.1875).
- Overflow: a=0.5; beats (0x64000000, 0x01000000) twice, so sum=200.0.
  - With DELTA_HID_SAT_EN: o_delta=0x1FFFFFFF.
  - Without: o_delta=0xF2000000 (-14.0).
- Zero derivative: a=0 or a=0x01000000, any beats -> o_delta=0.
- Hold/ignore: leave i_ack low for 5 cycles while pulsing i_start and i_valid. o_valid and o_delta stay stable. Assert i_ack -> o_valid=0 and o_busy=0 the next cycle.
- Reset mid-ACC: assert rst after one beat -> all outputs at reset values. A fresh Basic sequence then yields 0x00400000 with no carry-over.

Source files
------------

// File: rtl/delta_hid_pkg.sv
// delta_pkg: shared types and helpers for the hidden-layer delta engine.
// Holds the FSM state encoding, the fixed-point ONE constant and a
// signed saturate helper used by fx_mult and delta_hid.
package delta_pkg;

    // Operation phases of delta_hid.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        SD   = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_t;

    // 1.0 in a fixed-point format with frac fractional bits.
    function automatic logic [127:0] fx_one(input int frac);
        return 128'd1 << frac;
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    // The caller keeps the low w bits of the result.
    function automatic logic signed [127:0] sat_signed(input logic signed [127:0] x,
                                                       input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/delta_hid_fx_mult.sv
// fx_mult: combinational signed fixed-point multiply.
// Full 2*WIDTH product, arithmetic shift right by FRAC (floor), then either
// the low WIDTH bits (SAT=0) or a clamp to the WIDTH signed range (SAT=1).
module fx_mult
    import delta_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter bit SAT   = 1'b0
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;

    assign prod    = a * b;
    assign shifted = prod >>> FRAC;

    generate
        if (SAT) begin : g_sat
            logic signed [127:0] wide;
            logic signed [127:0] clamped;
            logic                unused_hi;
            assign wide      = 128'(shifted);
            assign clamped   = sat_signed(wide, WIDTH);
            assign y         = clamped[WIDTH-1:0];
            assign unused_hi = ^clamped[127:WIDTH];
        end else begin : g_wrap
            logic unused_hi;
            assign y         = shifted[WIDTH-1:0];
            assign unused_hi = ^shifted[2*WIDTH-1:WIDTH];
        end
    endgenerate

endmodule

// File: rtl/delta_hid.sv
// delta_hid: hidden-layer backprop delta engine.
// delta_h = clip(sum_k fmul(delta_k, w_k)) * fmul(a, 1 - a), signed fixed point.
// Build option: define DELTA_HID_SAT_EN to saturate the accumulator clip and
// the final product instead of wrapping them.
//
// Handshakes: an input beat transfers on a rising edge where i_valid && o_ready
// (o_ready is high only in ACC). A result is offered with o_valid and stays
// stable until an edge where o_valid && i_ack; i_ack is ignored otherwise.
// The current FSM phase is visible on the internal signal `state` for checkers.
module delta_hid
    import delta_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int N_OUT = 2,
    parameter int GUARD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_delta,
    input  logic [WIDTH-1:0] i_w,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_delta,
    input  logic             i_ack,
    output logic             o_busy
);

`ifdef DELTA_HID_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int                      AW       = WIDTH + GUARD;
    localparam int                      CW       = $clog2(N_OUT + 1);
    localparam logic [127:0]            ONE_FULL = fx_one(FRAC);
    localparam logic signed [WIDTH-1:0] ONE      = ONE_FULL[WIDTH-1:0];
    localparam logic [CW-1:0]           LAST_CNT = CW'(N_OUT - 1);

    state_t                  state;
    state_t                  state_nx;
    logic signed [AW-1:0]    acc;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH-1:0] a_reg;
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0]        delta_q;

    logic signed [WIDTH-1:0] beat_prod;
    logic signed [AW-1:0]    beat_ext;
    logic signed [WIDTH-1:0] one_minus_a;
    logic signed [WIDTH-1:0] sd_prod;
    logic signed [WIDTH-1:0] acc_clip;
    logic signed [WIDTH-1:0] fin_prod;
    logic signed [127:0]     acc_wide;
    logic signed [127:0]     acc_sat;
    logic                    unused_sat_hi;

    // Per-beat product delta_k * w_k, always wrapped to WIDTH.
    fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(1'b0)) u_beat_mult (
        .a (i_delta),
        .b (i_w),
        .y (beat_prod)
    );

    // Sigmoid derivative a * (1 - a).
    fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(1'b0)) u_sd_mult (
        .a (a_reg),
        .b (one_minus_a),
        .y (sd_prod)
    );

    // Final product clip(acc) * sd; saturates only in the SAT build.
    fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(SAT_EN)) u_fin_mult (
        .a (acc_clip),
        .b (sd),
        .y (fin_prod)
    );

    assign beat_ext      = AW'(beat_prod);
    assign one_minus_a   = ONE - a_reg;
    assign acc_wide      = 128'(acc);
    assign acc_sat       = sat_signed(acc_wide, WIDTH);
    assign acc_clip      = SAT_EN ? acc_sat[WIDTH-1:0] : acc[WIDTH-1:0];
    assign unused_sat_hi = ^acc_sat[127:WIDTH];

    assign o_valid = (state == DONE);
    assign o_delta = delta_q;

    // State register; reset abandons any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the ready/busy outputs.
    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        o_busy   = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                o_ready = 1'b1;
                if (i_valid && (cnt == LAST_CNT)) begin
                    state_nx = SD;
                end
            end
            SD:      state_nx = MUL;
            MUL:     state_nx = DONE;
            DONE: begin
                if (i_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: activation latch, accumulator, derivative, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            a_reg   <= '0;
            sd      <= '0;
            delta_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_reg <= i_a;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ACC: begin
                    if (i_valid) begin
                        acc <= acc + beat_ext;
                        cnt <= cnt + 1'b1;
                    end
                end
                SD:      sd      <= sd_prod;
                MUL:     delta_q <= fin_prod;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delta_hid.sv
// tb_delta_hid: self-checking bench for delta_hid (WIDTH=32, FRAC=24, N_OUT=2).
// Expected results come from a plain-arithmetic model using 64-bit integers.
// Follows the DELTA_HID_SAT_EN build option when it is defined.
module tb_delta_hid;

    localparam int WIDTH = 32;
    localparam int FRAC  = 24;
    localparam int N_OUT = 2;
    localparam int GUARD = 8;

`ifdef DELTA_HID_SAT_EN
    localparam bit          SAT_BUILD = 1'b1;
    localparam logic [31:0] OVF_EXP   = 32'h1FFF_FFFF;
`else
    localparam bit          SAT_BUILD = 1'b0;
    localparam logic [31:0] OVF_EXP   = 32'hF200_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_a = '0;
    logic        i_valid = 1'b0;
    logic [31:0] i_delta = '0;
    logic [31:0] i_w = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_delta;
    logic        i_ack = 1'b0;
    logic        o_busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_beat_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_delta = '0;
    logic [31:0] exp_q[$];

    delta_hid #(.WIDTH(WIDTH), .FRAC(FRAC), .N_OUT(N_OUT), .GUARD(GUARD)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_valid (i_valid),
        .i_delta (i_delta),
        .i_w     (i_w),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_delta (o_delta),
        .i_ack   (i_ack),
        .o_busy  (o_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fmul_m(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        p = p >>> FRAC;
        return p[31:0];
    endfunction

    function automatic longint clamp32(input longint x);
        if (x > 64'sh7FFF_FFFF) return 64'sh7FFF_FFFF;
        if (x < -64'sh8000_0000) return -64'sh8000_0000;
        return x;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] d0, input logic [31:0] w0,
                                          input logic [31:0] d1, input logic [31:0] w1);
        longint      sum;
        longint      c;
        longint      p;
        logic [31:0] sdm;
        logic [31:0] sum_lo;
        sum    = longint'($signed(fmul_m(d0, w0))) + longint'($signed(fmul_m(d1, w1)));
        sum_lo = sum[31:0];
        c      = SAT_BUILD ? clamp32(sum) : longint'($signed(sum_lo));
        sdm    = fmul_m(a, 32'h0100_0000 - a);
        p      = (c * longint'($signed(sdm))) >>> FRAC;
        if (SAT_BUILD) p = clamp32(p);
        return p[31:0];
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            check("ready_valid_excl", 32'(o_ready && o_valid), 32'd0);
            if (o_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    check("result", o_delta, exp_q.pop_front());
                    check("latency", 32'(cyc - last_beat_cyc), 32'd2);
                end
            end else if (o_valid && prev_valid) begin
                check("hold_delta", o_delta, prev_delta);
            end
            prev_valid <= o_valid;
            prev_delta <= o_delta;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_delta"}, o_delta, 32'd0);
        check({tag, "_ready"}, 32'(o_ready), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One full operation; called at #1 after an edge with the DUT idle.
    task automatic run_op(input logic [31:0] a,
                          input logic [31:0] d0, input logic [31:0] w0,
                          input logic [31:0] d1, input logic [31:0] w1,
                          input logic [31:0] expv, input int max_gap,
                          input int hold_n, input bit end_rst);
        logic [31:0] bd[2];
        logic [31:0] bw[2];
        int          n;
        bd[0] = d0; bw[0] = w0;
        bd[1] = d1; bw[1] = w1;
        exp_q.push_back(expv);
        i_start = 1'b1;
        i_a     = a;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_acc", 32'(o_busy), 32'd1);
        for (int k = 0; k < N_OUT; k++) begin
            n = $urandom_range(0, max_gap);
            repeat (n) begin
                i_valid = 1'b0;
                i_start = 1'($urandom_range(0, 1));
                i_a     = $urandom();
                i_ack   = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            i_start = 1'b0;
            i_ack   = 1'b0;
            i_valid = 1'b1;
            i_delta = bd[k];
            i_w     = bw[k];
            check("ready_acc", 32'(o_ready), 32'd1);
            @(posedge clk); #1;
            last_beat_cyc = cyc;
            i_valid = 1'b0;
            i_delta = $urandom();
            i_w     = $urandom();
        end
        check("ready_after_last", 32'(o_ready), 32'd0);
        n = 0;
        while (!o_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_valid) begin
            check("result_timeout", 32'(o_valid), 32'd1);
            exp_q.delete();
            pulse_reset();
            return;
        end
        repeat (hold_n) begin
            i_start = 1'($urandom_range(0, 1));
            i_valid = 1'($urandom_range(0, 1));
            i_a     = $urandom();
            i_delta = $urandom();
            @(posedge clk); #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_busy", 32'(o_busy), 32'd1);
        end
        i_start = 1'b0;
        i_valid = 1'b0;
        if (end_rst) begin
            pulse_reset();
            check_reset_outputs("rst_done");
            return;
        end
        i_ack   = 1'b1;
        i_start = 1'($urandom_range(0, 1));
        i_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        i_ack   = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        check("ack_valid", 32'(o_valid), 32'd0);
        check("ack_busy", 32'(o_busy), 32'd0);
        check("ack_delta_keep", o_delta, expv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rd0, rw0, rd1, rw1;
        int          mode;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Model pins against hand-computed values.
        check("model_basic", model(32'h0080_0000, 32'h0080_0000, 32'h0100_0000,
                                   32'h0040_0000, 32'h0200_0000), 32'h0040_0000);
        check("model_negative", model(32'h00C0_0000, 32'hFF00_0000, 32'h0100_0000,
                                      32'h0000_0000, 32'h1234_5678), 32'hFFD0_0000);
        check("model_overflow", model(32'h0080_0000, 32'h6400_0000, 32'h0100_0000,
                                      32'h6400_0000, 32'h0100_0000), OVF_EXP);

        // Directed cases with literal expectations.
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 32'h0200_0000,
               32'h0040_0000, 0, 0, 1'b0);
        run_op(32'h00C0_0000, 32'hFF00_0000, 32'h0100_0000, 32'h0000_0000, 32'h1234_5678,
               32'hFFD0_0000, 3, 1, 1'b0);
        run_op(32'h0080_0000, 32'h6400_0000, 32'h0100_0000, 32'h6400_0000, 32'h0100_0000,
               OVF_EXP, 2, 2, 1'b0);
        run_op(32'h0000_0000, 32'h0300_0000, 32'h0200_0000, 32'hF000_0000, 32'h0100_0000,
               32'h0000_0000, 1, 0, 1'b0);
        run_op(32'h0100_0000, 32'h0300_0000, 32'h0200_0000, 32'hF000_0000, 32'h0100_0000,
               32'h0000_0000, 1, 0, 1'b0);
        // Long hold with i_start / i_valid pulsing while the result waits.
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 32'h0200_0000,
               32'h0040_0000, 0, 5, 1'b0);

        // Reset after one accepted beat abandons the operation.
        i_start = 1'b1;
        i_a     = 32'h0070_0000;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_valid = 1'b1;
        i_delta = 32'h0500_0000;
        i_w     = 32'h0300_0000;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("mid_acc_busy", 32'(o_busy), 32'd1);
        pulse_reset();
        check_reset_outputs("rst_acc");
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_acc_no_valid", 32'(o_valid), 32'd0);
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 32'h0200_0000,
               32'h0040_0000, 0, 0, 1'b0);

        // Reset while a result is being held.
        run_op(32'h00C0_0000, 32'hFF00_0000, 32'h0100_0000, 32'h0000_0000, 32'h1234_5678,
               32'hFFD0_0000, 0, 2, 1'b1);

        // Randomized operations against the model.
        for (int t = 0; t < 60; t++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                ra  = $urandom();
                rd0 = $urandom(); rw0 = $urandom();
                rd1 = $urandom(); rw1 = $urandom();
            end else begin
                ra  = $urandom_range(0, 32'h0100_0000);
                rd0 = $urandom_range(0, 32'h0800_0000) - 32'h0400_0000;
                rw0 = $urandom_range(0, 32'h0800_0000) - 32'h0400_0000;
                rd1 = $urandom_range(0, 32'h0800_0000) - 32'h0400_0000;
                rw1 = (mode == 2) ? $urandom() : ($urandom_range(0, 32'h0800_0000) - 32'h0400_0000);
            end
            run_op(ra, rd0, rw0, rd1, rw1, model(ra, rd0, rw0, rd1, rw1),
                   3, $urandom_range(0, 3), 1'b0);
        end

        repeat (2) begin
            @(posedge clk); #1;
        end
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
